// File: rtl/alu4_share_arb.sv
// Two-requester round-robin front end for the shared add/sub/eq-select/pass datapath.
// One operation in flight: IDLE accepts, BUSY computes, RESP holds the tagged result until taken.
module alu4_share_arb #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state_reg, state_next;
    logic               last_grant_reg, last_grant_next;
    logic [1:0]         op_reg;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic               id_reg;
    logic               rsp_id_reg;
    logic [WIDTH-1:0]   rsp_data_reg;
    logic [WIDTH-1:0]   result_next;

    logic [1:0]         valid_vec, ready_vec;
    logic               grant_id;
    logic               accept;

    assign valid_vec = {req1_valid, req0_valid};

    // Under contention the requester that lost last time wins; otherwise whoever is valid.
    assign grant_id = (req0_valid && req1_valid) ? ~last_grant_reg : req1_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            logic granted;
            assign granted       = (gi == 0) ? !grant_id : grant_id;
            assign ready_vec[gi] = rst_n && (state_reg == IDLE) && valid_vec[gi] && granted;
        end
    endgenerate

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];
    assign accept     = |ready_vec;

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next      = BUSY;
                    last_grant_next = grant_id;
                end
            end
            BUSY:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        result_next = a_reg;
        case (op_reg)
            2'b00:   result_next = a_reg + b_reg;
            2'b01:   result_next = a_reg - b_reg;
            2'b10:   result_next = (a_reg == b_reg) ? a_reg : a_reg + b_reg;
            default: result_next = a_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            op_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            id_reg         <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_data_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            if (accept) begin
                op_reg <= grant_id ? req1_op : req0_op;
                a_reg  <= grant_id ? req1_a  : req0_a;
                b_reg  <= grant_id ? req1_b  : req0_b;
                id_reg <= grant_id;
            end
            // Response registers only load on BUSY->RESP, so they stay frozen while stalled.
            if (state_reg == BUSY) begin
                rsp_data_reg <= result_next;
                rsp_id_reg   <= id_reg;
            end
        end
    end

    assign rsp_valid = (state_reg == RESP);
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;

endmodule

// File: doc/alu4_share_arb.md
# alu4_share_arb

Two-requester round-robin arbiter and sequencer for the shared 4-bit add/compare/select datapath. It accepts one operation at a time over a valid/ready handshake, runs it through a registered compute stage, and returns the tagged result on a response channel that supports backpressure. It sits between the two client blocks and the single datapath instance, so the datapath never sees overlapping operations.

## Interface
- WIDTH, 4, operand and result width in bits.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle (when valid).
- req0_op  input  2  opcode: 00 add, 01 sub, 10 eq-select, 11 pass.
- req0_a  input  WIDTH  operand a.
- req0_b  input  WIDTH  operand b.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_id  output  1  requester index that issued the operation.
- rsp_data  output  WIDTH  result.

## Operation
- FSM states:
  - IDLE -> BUSY on an accept (reqN_valid && reqN_ready).
  - BUSY -> RESP unconditionally.
  - RESP -> IDLE when rsp_ready. It stays in RESP otherwise.
- Exactly one operation is outstanding at a time. No accept is possible outside IDLE.
- reqN_ready is combinational and is 1 only when all of these hold: state is IDLE, reqN_valid is 1, N is granted, and rst_n is high.
- Grant rules:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted last time wins.
- last_grant register:
  - Updates only on an accept.
  - Reset value is 1, so requester 0 wins the first contention.
- On accept, the op, a, b and id are captured into operand registers. The requester's inputs are don't-care afterwards.
- Result is computed in BUSY from the captured operands and registered into rsp_data at the BUSY->RESP edge:
  - add: (a + b) mod 2^WIDTH, carry dropped.
  - sub: (a - b) mod 2^WIDTH, two's-complement wrap.
  - eq-select: (a == b) ? a : (a + b) mod 2^WIDTH.
  - pass: a.
- rsp_valid = (state == RESP). rsp_data and rsp_id are stable for as long as rsp_valid is 1 and rsp_ready is 0.
- Reset values: state IDLE, last_grant 1, rsp_valid 0, rsp_id 0, rsp_data 0, req0_ready 0, req1_ready 0.
- Reset mid-operation: rst_n low in BUSY or RESP drops the operation. No response is produced after reset is released.

## Timing
- Accept at edge t means the state is BUSY in cycle t+1, and rsp_valid is 1 in cycle t+2.
- Minimum latency from accept to rsp_valid is 2 cycles.
- Handshake in RESP at cycle t+2 with rsp_ready=1: state is IDLE in cycle t+3, and the next accept can occur at edge t+3.
- Maximum throughput is one operation per 3 cycles.
- rsp_ready held low stalls indefinitely. While stalled, both readies stay 0 and no requester is starved of fairness: last_grant is unchanged.
- Simultaneous valid from both requesters in IDLE: exactly one ready is 1. It is never both.
- Valid may drop before accept without penalty. The arbiter holds no grant state except last_grant.
- rsp_ready asserted outside RESP is ignored.

## Test plan
- Single add: req0 only, op=00, a=4'h9, b=4'h9 -> req0_ready=1 at the accept edge; two cycles later rsp_valid=1, rsp_id=0, rsp_data=4'h2.
- Contention after reset: both valid, req0 op=11 a=4'h5, req1 op=01 a=4'h3 b=4'h5.
  - First grant goes to req0, with rsp_data=4'h5.
  - Second grant goes to req1, with rsp_data=4'hE and rsp_id=1.
  - Readies are never both 1.
- Eq-select both branches:
  - a=4'h2, b=4'h2 -> 4'h2.
  - a=4'h2, b=4'h3 -> 4'h5.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id are stable and both readies stay 0. After rsp_ready=1, the state returns to IDLE and the next accept occurs exactly one cycle later.
- Reset mid-op: assert rst_n=0 in BUSY -> rsp_valid=0 and all outputs are at reset values immediately. After release, with no requests, rsp_valid stays 0 for 10 cycles.
